sram_port_arbiter: RTL

- Shares the single-port on-chip program RAM between two requesters:
  - the CPU memory interface;
  - the boot loader, which writes the initial program image and serves debug reads.
- Replaces the ad-hoc write-select mux in the top level.
- Sequences an exclusive boot-load phase, then arbitrates round-robin between the two requesters.
- Steers the RAM's one-cycle read data back to whichever requester issued the read.

---
 rtl/sram_port_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Shares the single-port program RAM between the CPU and the boot loader.
// It runs an exclusive load phase, then round-robin arbitration, and steers
// the one-cycle read data back to the requester that issued the read.
// Optional CPU address guard: define SRAM_ARB_ADDR_GUARD_EN.
module sram_port_arbiter #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 16,
    parameter bit LOAD_AT_RESET = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_done,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              loading,
    output logic              oob_err
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_LDR = 1'b1;

    state_t            state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_owner_q, rd_owner_d;
    logic              rd_oob_q, rd_oob_d;
    logic [ADDR_W-1:0] addr_hold_q;
    logic [DATA_W-1:0] data_hold_q;
    logic              cpu_oob;
    logic              cpu_gnt_c, ldr_gnt_c;

`ifdef SRAM_ARB_ADDR_GUARD_EN
    assign cpu_oob = |cpu_addr[15:ADDR_W];
`else
    assign cpu_oob = 1'b0;
`endif

    // Arbitration and load-phase sequencing
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        cpu_gnt_c    = 1'b0;
        ldr_gnt_c    = 1'b0;
        loading      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                loading   = 1'b1;
                ldr_gnt_c = ldr_req;
                if (ldr_done) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (cpu_req && ldr_req) begin
                    // Fairness: the requester that did not go last wins.
                    if (last_owner_q == OWNER_LDR) begin
                        cpu_gnt_c = 1'b1;
                    end else begin
                        ldr_gnt_c = 1'b1;
                    end
                end else begin
                    cpu_gnt_c = cpu_req;
                    ldr_gnt_c = ldr_req;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
        if (cpu_gnt_c) begin
            last_owner_d = OWNER_CPU;
        end else if (ldr_gnt_c) begin
            last_owner_d = OWNER_LDR;
        end
    end

    assign cpu_gnt = cpu_gnt_c;
    assign ldr_gnt = ldr_gnt_c;

    // RAM drive; address/data hold their last granted value when idle
    always_comb begin
        ram_address = addr_hold_q;
        ram_data    = data_hold_q;
        ram_wren    = 1'b0;
        ram_rden    = 1'b0;
        rd_pend_d   = 1'b0;
        rd_owner_d  = rd_owner_q;
        rd_oob_d    = 1'b0;
        if (cpu_gnt_c) begin
            ram_address = cpu_addr[ADDR_W-1:0];
            ram_data    = cpu_wdata;
            ram_wren    = cpu_we & ~cpu_oob;
            ram_rden    = ~cpu_we & ~cpu_oob;
            rd_pend_d   = ~cpu_we;
            rd_owner_d  = OWNER_CPU;
            rd_oob_d    = ~cpu_we & cpu_oob;
        end else if (ldr_gnt_c) begin
            ram_address = ldr_addr;
            ram_data    = ldr_wdata;
            ram_wren    = ldr_we;
            ram_rden    = ~ldr_we;
            rd_pend_d   = ~ldr_we;
            rd_owner_d  = OWNER_LDR;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= LOAD_AT_RESET ? ST_LOAD : ST_ARB;
            last_owner_q <= OWNER_LDR;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= OWNER_CPU;
            rd_oob_q     <= 1'b0;
            addr_hold_q  <= '0;
            data_hold_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
            rd_oob_q     <= rd_oob_d;
            addr_hold_q  <= ram_address;
            data_hold_q  <= ram_data;
        end
    end

    // Per-port read return: index 0 is the CPU, index 1 the loader
    logic [1:0]        port_rvalid;
    logic [DATA_W-1:0] port_rdata_c [2];
    logic [DATA_W-1:0] port_rdata_q [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            assign port_rvalid[gi]  = rd_pend_q && (rd_owner_q == 1'(gi));
            // A guarded out-of-range read completes with zero data.
            assign port_rdata_c[gi] = port_rvalid[gi] ? (rd_oob_q ? '0 : ram_q)
                                                      : port_rdata_q[gi];
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    port_rdata_q[gi] <= '0;
                end else begin
                    port_rdata_q[gi] <= port_rdata_c[gi];
                end
            end
        end
    endgenerate

    assign cpu_rvalid = port_rvalid[0];
    assign ldr_rvalid = port_rvalid[1];
    assign cpu_rdata  = port_rdata_c[0];
    assign ldr_rdata  = port_rdata_c[1];

`ifdef SRAM_ARB_ADDR_GUARD_EN
    logic oob_err_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            oob_err_q <= 1'b0;
        end else if (cpu_gnt_c && cpu_oob) begin
            oob_err_q <= 1'b1;
        end
    end

    assign oob_err = oob_err_q;
`else
    assign oob_err = 1'b0;
`endif

endmodule
